// File: rtl/wb_to_av_bridge.sv
// Wishbone B4 slave to Avalon-MM master bridge: each Wishbone beat becomes one
// single-beat Avalon transfer, with a watchdog that converts a stalled slave into wb_err_o.
module wb_to_av_bridge #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int burstw  = 8,
    parameter int timeout = 255
) (
    input  logic              av_clk_i,
    input  logic              av_rst_i,
    input  logic [aw-1:0]     wb_adr_i,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic [dw/8-1:0]   wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [dw-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [aw-1:0]     av_address_o,
    output logic [dw-1:0]     av_writedata_o,
    output logic [dw/8-1:0]   av_byteenable_o,
    output logic [burstw-1:0] av_burstcount_o,
    output logic              av_write_o,
    output logic              av_read_o,
    input  logic              av_waitrequest_i,
    input  logic              av_readdatavalid_i,
    input  logic [dw-1:0]     av_readdata_i,
    input  logic [1:0]        av_response_i
);

    typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_DATA, DONE} state_t;

    localparam int cw = (timeout > 1) ? $clog2(timeout + 1) : 1;
    localparam logic [cw-1:0] wd_last = cw'((timeout > 0) ? timeout - 1 : 0);

    state_t        state, state_n;
    logic [cw-1:0] wd_cnt;
    logic          aborted;
    logic          busy, live, wd_expired;
    logic          ack_n, err_n, write_n, read_n, load, capture;
    logic          unused_inputs;

    // Burst type information is not needed: every beat carries its own address.
    assign unused_inputs   = ^{wb_cti_i, wb_bte_i};
    assign av_burstcount_o = burstw'(1);

    assign busy       = (state == WR) || (state == RD_CMD) || (state == RD_DATA);
    assign live       = wb_cyc_i && !aborted;
    assign wd_expired = (timeout != 0) && (wd_cnt == wd_last);

    always_ff @(posedge av_clk_i or posedge av_rst_i) begin
        if (av_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A transfer abandoned by the master still runs to completion on Avalon,
    // only its acknowledge is swallowed.
    always_comb begin
        state_n = state;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        write_n = av_write_o;
        read_n  = av_read_o;
        load    = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
                    load = 1'b1;
                    if (wb_we_i) begin
                        write_n = 1'b1;
                        state_n = WR;
                    end else begin
                        read_n  = 1'b1;
                        state_n = RD_CMD;
                    end
                end
            end
            WR: begin
                if (!av_waitrequest_i) begin
                    write_n = 1'b0;
                    ack_n   = live;
                    state_n = DONE;
                end else if (wd_expired) begin
                    write_n = 1'b0;
                    err_n   = live;
                    state_n = DONE;
                end
            end
            RD_CMD: begin
                if (!av_waitrequest_i) begin
                    read_n = 1'b0;
                    if (av_readdatavalid_i) begin
                        capture = 1'b1;
                        ack_n   = live && (av_response_i == 2'b00);
                        err_n   = live && (av_response_i != 2'b00);
                        state_n = DONE;
                    end else begin
                        state_n = RD_DATA;
                    end
                end else if (wd_expired) begin
                    read_n  = 1'b0;
                    err_n   = live;
                    state_n = DONE;
                end
            end
            RD_DATA: begin
                if (av_readdatavalid_i) begin
                    capture = 1'b1;
                    ack_n   = live && (av_response_i == 2'b00);
                    err_n   = live && (av_response_i != 2'b00);
                    state_n = DONE;
                end else if (wd_expired) begin
                    err_n   = live;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge av_clk_i or posedge av_rst_i) begin
        if (av_rst_i) begin
            wb_ack_o        <= 1'b0;
            wb_err_o        <= 1'b0;
            av_write_o      <= 1'b0;
            av_read_o       <= 1'b0;
            wb_dat_o        <= '0;
            av_address_o    <= '0;
            av_writedata_o  <= '0;
            av_byteenable_o <= '0;
            aborted         <= 1'b0;
            wd_cnt          <= '0;
        end else begin
            wb_ack_o   <= ack_n;
            wb_err_o   <= err_n;
            av_write_o <= write_n;
            av_read_o  <= read_n;
            if (load) begin
                av_address_o    <= wb_adr_i;
                av_writedata_o  <= wb_dat_i;
                av_byteenable_o <= wb_sel_i;
            end
            if (capture) begin
                wb_dat_o <= av_readdata_i;
            end
            if (load) begin
                aborted <= 1'b0;
            end else if (busy && !wb_cyc_i) begin
                aborted <= 1'b1;
            end
            // Every state change restarts the watchdog, so each phase gets a full budget.
            if (state_n != state) begin
                wd_cnt <= '0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + cw'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_to_av_bridge.sv
// Directed bench for wb_to_av_bridge: single beats, errors, watchdog, burst and async reset.
module tb_wb_to_av_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 8;
    localparam int TO = 8;

    logic            av_clk_i = 1'b0;
    logic            av_rst_i = 1'b0;
    logic [AW-1:0]   wb_adr_i = '0;
    logic [DW-1:0]   wb_dat_i = '0;
    logic [DW/8-1:0] wb_sel_i = '0;
    logic            wb_we_i  = 1'b0;
    logic            wb_cyc_i = 1'b0;
    logic            wb_stb_i = 1'b0;
    logic [2:0]      wb_cti_i = '0;
    logic [1:0]      wb_bte_i = '0;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic [AW-1:0]   av_address_o;
    logic [DW-1:0]   av_writedata_o;
    logic [DW/8-1:0] av_byteenable_o;
    logic [BW-1:0]   av_burstcount_o;
    logic            av_write_o;
    logic            av_read_o;
    logic            av_waitrequest_i   = 1'b0;
    logic            av_readdatavalid_i = 1'b0;
    logic [DW-1:0]   av_readdata_i      = '0;
    logic [1:0]      av_response_i      = '0;

    wb_to_av_bridge #(.dw(DW), .aw(AW), .burstw(BW), .timeout(TO)) dut (
        .av_clk_i(av_clk_i), .av_rst_i(av_rst_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .av_address_o(av_address_o), .av_writedata_o(av_writedata_o),
        .av_byteenable_o(av_byteenable_o), .av_burstcount_o(av_burstcount_o),
        .av_write_o(av_write_o), .av_read_o(av_read_o),
        .av_waitrequest_i(av_waitrequest_i), .av_readdatavalid_i(av_readdatavalid_i),
        .av_readdata_i(av_readdata_i), .av_response_i(av_response_i)
    );

    always #5 av_clk_i = ~av_clk_i;

    // Step s of a vector is observed 1 ns after the s-th rising edge since stb was raised.
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          waitCycles;
        int          rdvDelay;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          dropStep;
        int          expReq;
        int          expAck;
        int          expErr;
        logic [31:0] expDat;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   passes = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge av_clk_i);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int acceptStep = 1 + v.waitCycles;
        int reqCycles = 0, ackStep = -1, errStep = -1, ackCount = 0, errCount = 0;
        bit seenCmd = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
        wb_adr_i = v.adr; wb_dat_i = v.wdat; wb_sel_i = v.sel; wb_cti_i = 3'b000;
        for (int s = 0; s < 30; s++) begin
            av_waitrequest_i   = (s >= 1) && (s < acceptStep);
            av_readdatavalid_i = !v.we && (s == acceptStep + v.rdvDelay);
            av_readdata_i      = av_readdatavalid_i ? v.rdata : 32'h0;
            av_response_i      = av_readdatavalid_i ? v.resp : 2'b00;
            if (av_write_o || av_read_o) begin
                reqCycles++;
                if (!seenCmd) begin
                    seenCmd = 1'b1;
                    checkOutput({name, ".kind"}, 64'(av_write_o), 64'(v.we));
                    checkOutput({name, ".addr"}, 64'(av_address_o), 64'(v.adr));
                    checkOutput({name, ".be"}, 64'(av_byteenable_o), 64'(v.sel));
                    checkOutput({name, ".burst"}, 64'(av_burstcount_o), 64'd1);
                    if (v.we) checkOutput({name, ".wdata"}, 64'(av_writedata_o), 64'(v.wdat));
                end
            end
            if (wb_ack_o) begin
                ackCount++;
                if (ackStep < 0) ackStep = s;
            end
            if (wb_err_o) begin
                errCount++;
                if (errStep < 0) errStep = s;
            end
            if (wb_ack_o || wb_err_o || s == v.dropStep) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            tick();
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        av_waitrequest_i = 1'b0; av_readdatavalid_i = 1'b0;
        checkOutput({name, ".reqCycles"}, 64'(reqCycles), 64'(v.expReq));
        checkOutput({name, ".ackStep"}, 64'(ackStep), 64'(v.expAck));
        checkOutput({name, ".ackCount"}, 64'(ackCount), (v.expAck >= 0) ? 64'd1 : 64'd0);
        checkOutput({name, ".errStep"}, 64'(errStep), 64'(v.expErr));
        checkOutput({name, ".errCount"}, 64'(errCount), (v.expErr >= 0) ? 64'd1 : 64'd0);
        checkOutput({name, ".dat"}, 64'(wb_dat_o), 64'(v.expDat));
    endtask

    task automatic runBurst();
        int beat = 0, transfers = 0, outstanding = 0, maxOut = 0, errs = 0, extra = 0;
        bit pending = 1'b0;
        logic [31:0] pendData = '0;
        logic [31:0] seenAdr[4];
        bit accept;
        for (int i = 0; i < 4; i++) seenAdr[i] = 32'hFFFF_FFFF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_adr_i = 32'h0; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
        av_waitrequest_i = 1'b0;
        for (int s = 0; s < 60 && beat < 4; s++) begin
            av_readdatavalid_i = pending;
            av_readdata_i      = pending ? pendData : 32'h0;
            av_response_i      = 2'b00;
            accept = av_read_o;
            if (accept) begin
                if (transfers < 4) seenAdr[transfers] = av_address_o;
                transfers++;
            end
            outstanding = outstanding + int'(accept) - int'(pending);
            if (outstanding > maxOut) maxOut = outstanding;
            if (wb_err_o) errs++;
            if (wb_ack_o) begin
                checkOutput($sformatf("burst.dat%0d", beat), 64'(wb_dat_o), 64'(beat * 4 + 32'h100));
                beat++;
                wb_adr_i = 32'(beat * 4);
                wb_cti_i = (beat == 3) ? 3'b111 : 3'b010;
                if (beat == 4) begin
                    wb_cyc_i = 1'b0;
                    wb_stb_i = 1'b0;
                end
            end
            pending  = accept;
            pendData = av_address_o + 32'h100;
            tick();
        end
        av_readdatavalid_i = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (av_read_o || av_write_o) extra++;
            tick();
        end
        wb_cti_i = 3'b000;
        checkOutput("burst.beats", 64'(beat), 64'd4);
        checkOutput("burst.transfers", 64'(transfers), 64'd4);
        checkOutput("burst.maxOutstanding", 64'(maxOut), 64'd1);
        checkOutput("burst.errs", 64'(errs), 64'd0);
        checkOutput("burst.extra", 64'(extra), 64'd0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("burst.addr%0d", i), 64'(seenAdr[i]), 64'(i * 4));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".ack"}, 64'(wb_ack_o), 64'd0);
        checkOutput({name, ".err"}, 64'(wb_err_o), 64'd0);
        checkOutput({name, ".write"}, 64'(av_write_o), 64'd0);
        checkOutput({name, ".read"}, 64'(av_read_o), 64'd0);
        checkOutput({name, ".dat"}, 64'(wb_dat_o), 64'd0);
        checkOutput({name, ".addr"}, 64'(av_address_o), 64'd0);
        checkOutput({name, ".wdata"}, 64'(av_writedata_o), 64'd0);
        checkOutput({name, ".be"}, 64'(av_byteenable_o), 64'd0);
    endtask

    initial begin
        int lateAcks = 0;
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0,  0, 32'h0,      2'b00, -1, 1, 2, -1, 32'h0};
        vecs[1] = '{1'b0, 32'h20, 32'h0,      4'hF, 3,  2, 32'h12345678, 2'b00, -1, 4, 7, -1, 32'h12345678};
        vecs[2] = '{1'b1, 32'h14, 32'h0BADF00D, 4'h3, 2, 0, 32'h0,      2'b00, -1, 3, 4, -1, 32'h12345678};
        vecs[3] = '{1'b0, 32'h24, 32'h0,      4'hC, 0,  0, 32'hCAFEF00D, 2'b10, -1, 1, -1, 2, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 32'h28, 32'h55AA55AA, 4'hF, 25, 0, 32'h0,     2'b00, -1, 8, -1, 9, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 32'h30, 32'h0,      4'hF, 1,  1, 32'hA5A50F0F, 2'b00, -1, 2, 4, -1, 32'hA5A50F0F};
        vecs[6] = '{1'b0, 32'h40, 32'h0,      4'hF, 2,  1, 32'h11112222, 2'b00, 2, 3, -1, -1, 32'h11112222};

        #2 av_rst_i = 1'b1;
        repeat (2) @(posedge av_clk_i);
        #1;
        checkAllZero("reset");
        checkOutput("reset.burstcount", 64'(av_burstcount_o), 64'd1);
        av_rst_i = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
        runBurst();

        // Leave a read parked in RD_DATA, then reset between clock edges.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h50; wb_sel_i = 4'hF; av_waitrequest_i = 1'b0;
        tick();
        checkOutput("rstmid.readIssued", 64'(av_read_o), 64'd1);
        tick();
        #2 av_rst_i = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #1;
        checkAllZero("rstmid");
        #1 av_rst_i = 1'b0;
        tick();
        av_readdatavalid_i = 1'b1;
        av_readdata_i = 32'h99998888;
        tick();
        av_readdatavalid_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (wb_ack_o || wb_err_o) lateAcks++;
            tick();
        end
        checkOutput("rstmid.lateAck", 64'(lateAcks), 64'd0);
        checkOutput("rstmid.dat", 64'(wb_dat_o), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
